geo_bank_regs: RTL and testbench
================================

# geo_bank_regs

Parametrised GeoRAM-style bank pointer register file for the cartridge CPLD. Holds NCH independent {Block, Window} page pointers, selected by a control register, with byte-wide register readback and an optional auto-increment mode that advances the active pointer by one page after each access to the last byte of the window page. It sits between the C64 bus decode (RegSEL/WinSEL) and the RAM address generator, and drives the upper RAM address bits from the selected channel.

## Interface
- BLOCK_W, 8: Block register width, 1..8.
- WINDOW_W, 6: Window register width, 1..8.
- NCH, 4: number of pointer channels, power of two, 1..64; CH_W = max(1, clog2(NCH)).
- PHI2  in  1  C64 PHI2 clock; all state updates on the falling edge of PHI2.
- RESET  in  1  reset, synchronous, active-high, sampled on the same falling edge of PHI2.
- RegSEL  in  1  register page access (IO2 page) this bus cycle.
- WinSEL  in  1  window page access (IO1 page) this bus cycle.
- nWE  in  1  C64 write strobe, low = write.
- A  in  8  C64 A[7:0].
- WRD  in  8  write data from C64.
- RDD  out  8  readback data, combinational.
- RDOE  out  1  readback drive enable, combinational.
- Block  out  BLOCK_W  Block pointer of selected channel.
- Window  out  WINDOW_W  Window pointer of selected channel.
- Chan  out  CH_W  selected channel index.

## Operation
- Register map (RegSEL=1, full 8-bit decode of A): 0xFF Block, 0xFE Window, 0xFD Control, 0xFC Status (read-only). All other A: writes ignored, RDOE=0.
- Control: bit0 AINC (auto-increment enable, per device, not per channel); bits[1+CH_W:2] channel select; bit1 and unused upper bits read 0, writes ignored.
- Status: bit0 WRAP flag of selected channel; other bits 0.
- Block/Window writes load WRD[BLOCK_W-1:0] / WRD[WINDOW_W-1:0] into the selected channel only; other channels untouched.
- Control write: loads AINC and channel select, clears WRAP on all channels.
- Reads (RegSEL=1, nWE=1, decoded A): RDOE=1, RDD = register value zero-extended to 8 bits. Reads have no side effects. RDOE=0 forces RDD=0.
- Auto-increment: when AINC=1, WinSEL=1, RegSEL=0 and A=0xFF (read or write), the selected channel's pointer P = {Block, Window} (BLOCK_W+WINDOW_W bits, Window LSBs) increments by 1 at the end of that cycle. Window all-ones carries into Block. P all-ones wraps to 0 and sets that channel's WRAP flag.
- Simultaneous RegSEL and WinSEL: register access performed, increment suppressed.
- WinSEL with A!=0xFF or AINC=0: no state change.

## Timing
- One PHI2 period per bus cycle; register writes and increments take effect on the falling edge ending the cycle; Block/Window/Chan reflect new values immediately after that edge (the triggering window access uses pre-increment pointer).
- RDD/RDOE valid combinationally within the same cycle from current state and A/RegSEL/nWE.
- WinSEL held for N consecutive falling edges with A=0xFF yields N increments.
- Channel switch via Control write: Block/Window outputs switch to the new channel after the edge; increments before that edge apply to the old channel.
- RESET=1 at a falling edge: all channels Block=0, Window=0, WRAP=0; AINC=0; Chan=0. RESET overrides any concurrent write or increment. Outputs remain 0 while RESET held; first write accepted on the first edge with RESET=0.
- No multi-cycle operations; reset mid-sequence leaves no pending state.

## Test plan
- Reset then read: RESET 1 edge, read 0xFF/0xFE/0xFD/0xFC -> RDD 0x00 each, RDOE=1; read 0xFB -> RDOE=0, RDD=0x00.
- Write/readback, defaults: write 0xFF=0xA5, 0xFE=0xFF -> Block=0xA5, Window=0x3F, read 0xFE -> 0x3F.
- Channels: ch0 Block=0x11; Control=0x04 (ch1); Block=0x22 -> Block=0x22, Chan=1; Control=0x00 -> Block=0x11.
- Auto-increment carry/wrap: Control=0x01, Block=0xFF, Window=0x3E; three WinSEL A=0xFF accesses -> {0xFF,0x3F}, {0x00,0x00}, {0x00,0x01}; Status reads 0x01; Control write 0x01 -> Status 0x00.
- Suppression: AINC=1, RegSEL=WinSEL=1, A=0xFF write 0x07 -> Block=0x07, Window unchanged; WinSEL with A=0xFE -> no change.
- Reset mid-operation: AINC=1, RESET asserted on the same edge as a Block write and a window increment -> all outputs 0, Control reads 0x00.

Source files
------------

// File: rtl/geo_bank_regs.sv
// geo_bank_regs: GeoRAM-style bank pointer register file.
// Holds NCH independent {Block, Window} page pointers. The Control register
// picks the active channel, and the C64 reads those registers back byte by byte.
// Optional auto-increment advances the active pointer by one page after each
// access to the last byte (0xFF) of the window page.
// All state changes on the falling edge of PHI2, which ends each C64 bus cycle.
module geo_bank_regs #(
   parameter int BLOCK_W  = 8,
   parameter int WINDOW_W = 6,
   parameter int NCH      = 4,
   localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                PHI2,
   input  logic                RESET,
   input  logic                RegSEL,
   input  logic                WinSEL,
   input  logic                nWE,
   input  logic [7:0]          A,
   input  logic [7:0]          WRD,
   output logic [7:0]          RDD,
   output logic                RDOE,
   output logic [BLOCK_W-1:0]  Block,
   output logic [WINDOW_W-1:0] Window,
   output logic [CH_W-1:0]     Chan
);

   localparam int PW = BLOCK_W + WINDOW_W;
   // With a single channel the select field still has one bit. Masking
   // the select field keeps the index inside the channel array.
   localparam logic [CH_W-1:0] CH_MASK = CH_W'(NCH - 1);

   localparam logic [7:0] ADDR_BLOCK   = 8'hFF;
   localparam logic [7:0] ADDR_WINDOW  = 8'hFE;
   localparam logic [7:0] ADDR_CONTROL = 8'hFD;
   localparam logic [7:0] ADDR_STATUS  = 8'hFC;

   logic [BLOCK_W-1:0]  r_block  [NCH];
   logic [WINDOW_W-1:0] r_window [NCH];
   logic [NCH-1:0]      r_wrap;
   logic                r_ainc;
   logic [CH_W-1:0]     r_chan;

   logic [PW-1:0]       w_ptr;
   logic [PW-1:0]       w_ptr_nxt;
   logic                w_ptr_max;
   logic                w_reg_wr;
   logic                w_inc;

   // Pointer of the active channel, with Window in the LSBs so that a
   // carry out of Window moves into Block.
   assign w_ptr     = {r_block[r_chan], r_window[r_chan]};
   assign w_ptr_nxt = w_ptr + PW'(1);
   assign w_ptr_max = &w_ptr;

   // A register access has priority over a window access in the same cycle.
   // The increment condition therefore requires RegSEL to be low.
   assign w_reg_wr = RegSEL & ~nWE;
   assign w_inc    = r_ainc & WinSEL & ~RegSEL & (A == 8'hFF);

   assign Block  = r_block[r_chan];
   assign Window = r_window[r_chan];
   assign Chan   = r_chan;

   // Register writes, auto-increment and synchronous reset on the PHI2 falling edge.
   always_ff @(negedge PHI2) begin
      if (RESET) begin
         for (int i = 0; i < NCH; i++) begin
            r_block[i]  <= '0;
            r_window[i] <= '0;
         end
         r_wrap <= '0;
         r_ainc <= 1'b0;
         r_chan <= '0;
      end else if (w_reg_wr) begin
         case (A)
            ADDR_BLOCK:   r_block[r_chan]  <= WRD[BLOCK_W-1:0];
            ADDR_WINDOW:  r_window[r_chan] <= WRD[WINDOW_W-1:0];
            ADDR_CONTROL: begin
               r_ainc <= WRD[0];
               r_chan <= WRD[1+CH_W:2] & CH_MASK;
               r_wrap <= '0;
            end
            default: ;
         endcase
      end else if (w_inc) begin
         r_block[r_chan]  <= w_ptr_nxt[PW-1:WINDOW_W];
         r_window[r_chan] <= w_ptr_nxt[WINDOW_W-1:0];
         if (w_ptr_max) begin
            r_wrap[r_chan] <= 1'b1;
         end
      end
   end

   // Combinational readback. Reads have no side effects. Data is held at
   // zero whenever the output enable is low.
   always_comb begin
      RDD  = 8'h00;
      RDOE = 1'b0;
      if (RegSEL && nWE) begin
         case (A)
            ADDR_BLOCK: begin
               RDD  = 8'(r_block[r_chan]);
               RDOE = 1'b1;
            end
            ADDR_WINDOW: begin
               RDD  = 8'(r_window[r_chan]);
               RDOE = 1'b1;
            end
            ADDR_CONTROL: begin
               RDD  = 8'({r_chan, 1'b0, r_ainc});
               RDOE = 1'b1;
            end
            ADDR_STATUS: begin
               RDD  = {7'b0, r_wrap[r_chan]};
               RDOE = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_geo_bank_regs.sv
// Directed testbench for geo_bank_regs with the default parameters
// (8-bit Block, 6-bit Window, 4 channels).
// Expected results go onto queues when stimulus is driven. They are popped
// and compared once the DUT output has settled.
module tb_geo_bank_regs;

   logic       PHI2;
   logic       RESET;
   logic       RegSEL;
   logic       WinSEL;
   logic       nWE;
   logic [7:0] A;
   logic [7:0] WRD;
   logic [7:0] RDD;
   logic       RDOE;
   logic [7:0] Block;
   logic [5:0] Window;
   logic [1:0] Chan;

   int n_vec  = 0;
   int n_fail = 0;

   // readback queue: {RDOE, RDD}; pointer queue: {Block, Window, Chan}
   logic [8:0]  exp_q[$];
   logic [15:0] ptr_q[$];

   geo_bank_regs #(.BLOCK_W(8), .WINDOW_W(6), .NCH(4)) dut (
      .PHI2(PHI2), .RESET(RESET), .RegSEL(RegSEL), .WinSEL(WinSEL), .nWE(nWE),
      .A(A), .WRD(WRD), .RDD(RDD), .RDOE(RDOE), .Block(Block), .Window(Window),
      .Chan(Chan)
   );

   // clock / reset block
   initial begin
      PHI2 = 1'b1;
      forever #10 PHI2 = ~PHI2;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   // One full bus cycle: drive the inputs, then let the falling edge commit them.
   task automatic cyc(input logic rst, input logic rs, input logic ws, input logic wn,
                      input logic [7:0] a, input logic [7:0] d);
      RESET = rst; RegSEL = rs; WinSEL = ws; nWE = wn; A = a; WRD = d;
      @(negedge PHI2);
      #2;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, a, d);
   endtask

   task automatic win_acc(input logic [7:0] a);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, a, 8'h00);
   endtask

   // Register read: check combinational readback mid-cycle, then finish the cycle.
   task automatic rd(input string tag, input logic [7:0] a,
                     input logic oe, input logic [7:0] d);
      logic [8:0] e;
      logic [8:0] o;
      RESET = 1'b0; RegSEL = 1'b1; WinSEL = 1'b0; nWE = 1'b1; A = a; WRD = 8'h00;
      exp_q.push_back({oe, d});
      #1;
      e = exp_q.pop_front();
      o = {RDOE, RDD};
      n_vec++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: RDOE/RDD obs=%h exp=%h", tag, o, e);
      end
      @(negedge PHI2);
      #2;
   endtask

   task automatic chk_ptr(input string tag, input logic [7:0] b,
                          input logic [5:0] w, input logic [1:0] c);
      logic [15:0] e;
      logic [15:0] o;
      ptr_q.push_back({b, w, c});
      e = ptr_q.pop_front();
      o = {Block, Window, Chan};
      n_vec++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: {Block,Window,Chan} obs=%h exp=%h", tag, o, e);
      end
   endtask

   initial begin
      RESET = 1'b1; RegSEL = 1'b0; WinSEL = 1'b0; nWE = 1'b1; A = 8'h00; WRD = 8'h00;
      @(negedge PHI2);
      @(negedge PHI2);
      #2;
      chk_ptr("reset_held", 8'h00, 6'h00, 2'd0);
      RESET = 1'b0;

      // reset then read
      rd("rst_rd_block",   8'hFF, 1'b1, 8'h00);
      rd("rst_rd_window",  8'hFE, 1'b1, 8'h00);
      rd("rst_rd_control", 8'hFD, 1'b1, 8'h00);
      rd("rst_rd_status",  8'hFC, 1'b1, 8'h00);
      rd("rd_unmapped",    8'hFB, 1'b0, 8'h00);

      // write / readback with width truncation
      wr_reg(8'hFF, 8'hA5);
      wr_reg(8'hFE, 8'hFF);
      chk_ptr("wr_block_window", 8'hA5, 6'h3F, 2'd0);
      rd("rd_window_3f", 8'hFE, 1'b1, 8'h3F);
      rd("rd_block_a5",  8'hFF, 1'b1, 8'hA5);

      // channels
      wr_reg(8'hFF, 8'h11);
      wr_reg(8'hFD, 8'h04);
      chk_ptr("ch1_fresh", 8'h00, 6'h00, 2'd1);
      wr_reg(8'hFF, 8'h22);
      chk_ptr("ch1_block", 8'h22, 6'h00, 2'd1);
      rd("rd_control_04", 8'hFD, 1'b1, 8'h04);
      wr_reg(8'hFD, 8'h00);
      chk_ptr("ch0_back", 8'h11, 6'h3F, 2'd0);
      // bit1 and the upper unused bits are not stored
      wr_reg(8'hFD, 8'hF2);
      rd("rd_control_mask", 8'hFD, 1'b1, 8'h00);

      // auto-increment carry and wrap
      wr_reg(8'hFD, 8'h01);
      wr_reg(8'hFF, 8'hFF);
      wr_reg(8'hFE, 8'h3E);
      chk_ptr("ainc_setup", 8'hFF, 6'h3E, 2'd0);
      win_acc(8'hFF);
      chk_ptr("ainc_1", 8'hFF, 6'h3F, 2'd0);
      rd("status_nowrap", 8'hFC, 1'b1, 8'h00);
      win_acc(8'hFF);
      chk_ptr("ainc_wrap", 8'h00, 6'h00, 2'd0);
      win_acc(8'hFF);
      chk_ptr("ainc_3", 8'h00, 6'h01, 2'd0);
      rd("status_wrap", 8'hFC, 1'b1, 8'h01);
      rd("rd_control_01", 8'hFD, 1'b1, 8'h01);
      wr_reg(8'hFD, 8'h05);
      chk_ptr("ch1_untouched", 8'h22, 6'h00, 2'd1);
      rd("status_cleared_ch1", 8'hFC, 1'b1, 8'h00);
      wr_reg(8'hFD, 8'h01);
      rd("status_cleared", 8'hFC, 1'b1, 8'h00);

      // suppression and no-effect window accesses
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h07);
      chk_ptr("both_sel", 8'h07, 6'h01, 2'd0);
      win_acc(8'hFE);
      chk_ptr("win_not_ff", 8'h07, 6'h01, 2'd0);
      wr_reg(8'hFB, 8'h55);
      chk_ptr("wr_unmapped", 8'h07, 6'h01, 2'd0);
      win_acc(8'hFF);
      win_acc(8'hFF);
      win_acc(8'hFF);
      chk_ptr("ainc_burst3", 8'h07, 6'h04, 2'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h99);
      chk_ptr("ainc_on_write", 8'h07, 6'h05, 2'd0);
      wr_reg(8'hFD, 8'h00);
      win_acc(8'hFF);
      chk_ptr("ainc_off", 8'h07, 6'h05, 2'd0);

      // reset mid-operation
      wr_reg(8'hFD, 8'h05);
      wr_reg(8'hFF, 8'h33);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
      chk_ptr("rst_vs_inc", 8'h00, 6'h00, 2'd0);
      rd("rst_control", 8'hFD, 1'b1, 8'h00);
      wr_reg(8'hFD, 8'h05);
      wr_reg(8'hFF, 8'h44);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h99);
      chk_ptr("rst_vs_write", 8'h00, 6'h00, 2'd0);
      rd("rst_control2", 8'hFD, 1'b1, 8'h00);
      wr_reg(8'hFD, 8'h04);
      chk_ptr("rst_cleared_ch1", 8'h00, 6'h00, 2'd1);
      wr_reg(8'hFF, 8'h5A);
      chk_ptr("first_write", 8'h5A, 6'h00, 2'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
